// File: rtl/mult_div_unit_pkg.sv
// Shared opcode/state encodings and decode helpers for the multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mduOp_t;

    typedef enum logic {
        MDU_S_IDLE = 1'b0,
        MDU_S_BUSY = 1'b1
    } mduState_t;

    localparam int DATA_W = 32;

    // True for the opcodes that occupy the unit for several cycles.
    function automatic logic isMulDiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // True for the two divide opcodes.
    function automatic logic isDiv(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the MDU.
interface mult_div_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, hi, lo, mdu_out
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, hi, lo, mdu_out
    );
endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational {hi,lo} result for mult/multu/div/divu plus divide-by-zero flag.
module mult_div_unit_arith
    import mult_div_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [63:0] result,
    output logic        divByZero
);

    logic [63:0] signedProd;
    logic [63:0] unsignedProd;
    logic        isZero;
    logic [31:0] divisor;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] magQuot;
    logic [31:0] magRem;
    logic [31:0] sQuot;
    logic [31:0] sRem;
    logic [31:0] uQuot;
    logic [31:0] uRem;

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
    assign signedProd   = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign unsignedProd = {32'd0, srcA} * {32'd0, srcB};

    // A zero divisor is swapped for 1 so the dividers never see it; the result is discarded anyway.
    assign isZero  = (srcB == 32'd0);
    assign divisor = isZero ? 32'd1 : srcB;

    // Signed divide on magnitudes: quotient sign is the XOR of operand signs, remainder follows the
    // dividend. 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    assign magA    = srcA[31] ? (~srcA + 32'd1) : srcA;
    assign magB    = divisor[31] ? (~divisor + 32'd1) : divisor;
    assign magQuot = magA / magB;
    assign magRem  = magA % magB;
    assign sQuot   = (srcA[31] ^ divisor[31]) ? (~magQuot + 32'd1) : magQuot;
    assign sRem    = srcA[31] ? (~magRem + 32'd1) : magRem;

    assign uQuot = srcA / divisor;
    assign uRem  = srcA % divisor;

    // Select the 64-bit {hi,lo} image for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result    = 64'd0;
        divByZero = isDiv(op) && isZero;
        case (op)
            MDU_MULT:  result = signedProd;
            MDU_MULTU: result = unsignedProd;
            MDU_DIV:   result = {sRem, sQuot};
            MDU_DIVU:  result = {uRem, uQuot};
            default:   result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, models fixed multi-cycle latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    mduState_t          state;
    logic [CNT_W-1:0]   counter;
    logic [31:0]        pendHi;
    logic [31:0]        pendLo;
    logic               pendValid;
    logic [31:0]        hiReg;
    logic [31:0]        loReg;
    logic               busyReg;

    logic [63:0]        arithResult;
    logic               arithDivByZero;
    logic               accept;
    logic               writeHi;
    logic               writeLo;

    mult_div_unit_arith uArith (
        .op        (bus.op),
        .srcA      (bus.src_a),
        .srcB      (bus.src_b),
        .result    (arithResult),
        .divByZero (arithDivByZero)
    );

    // Starts are only taken from IDLE; a start while busy is dropped without touching the counter.
    assign accept  = bus.start && !bus.cancel && isMulDiv(bus.op) && (state == MDU_S_IDLE);
    assign writeHi = (bus.op == MDU_MTHI) && !bus.cancel;
    assign writeLo = (bus.op == MDU_MTLO) && !bus.cancel;

    // FSM, latency counter, pending result and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MDU_S_IDLE;
            counter   <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendValid <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
            busyReg   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the commit below is placed after the move-to writes so
            // that, on the same edge, the in-flight result overrides an mthi/mtlo.
            if (writeHi) hiReg <= bus.src_a;
            if (writeLo) loReg <= bus.src_a;

            case (state)
                MDU_S_IDLE: begin
                    if (accept) begin
                        state     <= MDU_S_BUSY;
                        busyReg   <= 1'b1;
                        counter   <= isDiv(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        pendHi    <= arithResult[63:32];
                        pendLo    <= arithResult[31:0];
                        pendValid <= !arithDivByZero;
                    end
                end
                MDU_S_BUSY: begin
                    if (counter == CNT_W'(1)) begin
                        state   <= MDU_S_IDLE;
                        busyReg <= 1'b0;
                        if (pendValid) begin
                            hiReg <= pendHi;
                            loReg <= pendLo;
                        end
                    end
                    if (counter != '0) counter <= counter - CNT_W'(1);
                end
                default: begin
                    state   <= MDU_S_IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    // mfhi/mflo read port; zero for every other opcode.
    always_comb begin
        bus.mdu_out = 32'd0;
        if (bus.op == MDU_MFHI)      bus.mdu_out = hiReg;
        else if (bus.op == MDU_MFLO) bus.mdu_out = loReg;
    end

    assign bus.busy = busyReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus hand-written corner sequences.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MULT_N     = 5;
    localparam int DIV_N      = 10;
    localparam int WAIT_LIMIT = 40;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;
    res_t        sb[$];
    vec_t        vecs[10];

    mult_div_unit_if bus();

    mult_div_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge; they are sampled at the following edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic cn);
        @(posedge clk);
        #1;
        bus.op     = op;
        bus.src_a  = a;
        bus.src_b  = b;
        bus.start  = st;
        bus.cancel = cn;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.op     = MDU_NONE;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
    endtask

    // Count consecutive busy cycles (sampled on falling edges) and confirm HI/LO hold meanwhile.
    task automatic countBusy(output int n, output logic held);
        n    = 0;
        held = 1'b1;
        for (int k = 0; k < WAIT_LIMIT; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (bus.hi !== modelHi || bus.lo !== modelLo) held = 1'b0;
        end
    endtask

    task automatic expectResult(input string name);
        res_t r;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got no expected entry", name);
        end else begin
            r = sb.pop_front();
            check({name, " hi"}, bus.hi, r.hi);
            check({name, " lo"}, bus.lo, r.lo);
            modelHi = r.hi;
            modelLo = r.lo;
        end
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                         input int cycles);
        int   n;
        logic held;
        sb.push_back('{expHi, expLo});
        drive(op, a, b, 1'b1, 1'b0);
        idle();
        countBusy(n, held);
        check({name, " busy cycles"}, 32'(n), 32'(cycles));
        check({name, " hi/lo held while busy"}, {31'd0, held}, 32'd1);
        expectResult(name);
    endtask

    task automatic moveTo(input logic toHi, input logic [31:0] value);
        drive(toHi ? MDU_MTHI : MDU_MTLO, value, 32'd0, 1'b0, 1'b0);
        idle();
        if (toHi) begin
            modelHi = value;
            check("mthi", bus.hi, modelHi);
        end else begin
            modelLo = value;
            check("mtlo", bus.lo, modelLo);
        end
    endtask

    task automatic readBack(input string name);
        bus.op = MDU_MFHI;
        #1 check({name, " mfhi"}, bus.mdu_out, modelHi);
        bus.op = MDU_MFLO;
        #1 check({name, " mflo"}, bus.mdu_out, modelLo);
        bus.op = MDU_NONE;
        #1 check({name, " mdu_out none"}, bus.mdu_out, 32'd0);
    endtask

    initial begin
        int   n;
        int   pre;
        logic held;

        vecs[0] = '{"mult -2x3",        MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MULT_N};
        vecs[1] = '{"multu 0xFFFFFFFEx3", MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MULT_N};
        vecs[2] = '{"mult min*min",     MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_N};
        vecs[3] = '{"multu max*max",    MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULT_N};
        vecs[4] = '{"div -7/2",         MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
        vecs[5] = '{"divu 7/2",         MDU_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DIV_N};
        vecs[6] = '{"div 7/-2",         MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_N};
        vecs[7] = '{"div -7/-2",        MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DIV_N};
        vecs[8] = '{"div min/-1",       MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_N};
        vecs[9] = '{"divu max/16",      MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DIV_N};

        bus.start  = 1'b0;
        bus.op     = MDU_NONE;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        bus.cancel = 1'b0;
        reset      = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        reset = 1'b0;

        // Asynchronous reset clears HI/LO before any clock edge.
        moveTo(1'b1, 32'h00001234);
        moveTo(1'b0, 32'h00005678);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset hi", bus.hi, 32'd0);
        check("async reset lo", bus.lo, 32'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].expHi, vecs[i].expLo, vecs[i].cycles);
        end
        readBack("after table");

        // Divide by zero keeps the values written by mthi/mtlo.
        moveTo(1'b1, 32'h00000011);
        moveTo(1'b0, 32'h00000022);
        runOp("div 5/0", MDU_DIV, 32'd5, 32'd0, 32'h00000011, 32'h00000022, DIV_N);

        // Cancelled start and cancelled mtlo leave state untouched.
        drive(MDU_MULT, 32'd2, 32'd3, 1'b1, 1'b1);
        idle();
        countBusy(n, held);
        check("cancel mult busy cycles", 32'(n), 32'd0);
        check("cancel mult hi", bus.hi, modelHi);
        check("cancel mult lo", bus.lo, modelLo);
        drive(MDU_MTLO, 32'h00000055, 32'd0, 1'b0, 1'b1);
        idle();
        check("cancel mtlo lo", bus.lo, modelLo);

        // Unknown opcode with start is a no-op.
        drive(4'hF, 32'd9, 32'd9, 1'b1, 1'b0);
        idle();
        countBusy(n, held);
        check("unknown op busy cycles", 32'(n), 32'd0);
        check("unknown op hi", bus.hi, modelHi);

        // Second start in cycle 2 of a busy mult is ignored.
        sb.push_back('{32'h00000001, 32'h00000000});
        drive(MDU_MULT, 32'h00010000, 32'h00010000, 1'b1, 1'b0);
        idle();
        pre = 0;
        @(negedge clk);
        if (bus.busy) pre++;
        drive(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        @(negedge clk);
        if (bus.busy) pre++;
        idle();
        countBusy(n, held);
        check("restart ignored busy cycles", 32'(pre + n), 32'(MULT_N));
        expectResult("restart ignored");

        // mthi while busy lands at once; the divide result then overwrites both HI and LO.
        sb.push_back('{32'd2, 32'd14});
        drive(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        idle();
        drive(MDU_MTHI, 32'h000000AA, 32'd0, 1'b0, 1'b0);
        idle();
        check("mthi while busy", bus.hi, 32'h000000AA);
        modelHi = 32'h000000AA;
        countBusy(n, held);
        check("mthi while busy remaining cycles", 32'(n), 32'(DIV_N - 2));
        check("mthi while busy held", {31'd0, held}, 32'd1);
        expectResult("div after mthi");
        readBack("after overlap");

        // Reset in cycle 3 of a divide aborts it and clears HI/LO.
        drive(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("reset mid-div busy", {31'd0, bus.busy}, 32'd0);
        check("reset mid-div hi", bus.hi, 32'd0);
        check("reset mid-div lo", bus.lo, 32'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        countBusy(n, held);
        check("after reset busy cycles", 32'(n), 32'd0);
        check("after reset hi", bus.hi, 32'd0);

        // Unit resumes normal operation after the abort.
        runOp("mult 7x6", MDU_MULT, 32'd7, 32'd6, 32'd0, 32'd42, MULT_N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
